// File: rtl/top.sv
// Ascon-128 encryption core: iterative, one permutation round per clock.
// Free-running: every 44 cycles it loads SK/N/A/P, encrypts one 64-bit
// associated-data block and one 64-bit plaintext block, and publishes C/T.
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   SK   - 128-bit key, SK[127:64] is key word 0
//   N    - 128-bit nonce, N[127:64] is nonce word 0
//   A    - 64-bit associated-data block
//   P    - 64-bit plaintext block
//   C    - registered ciphertext block
//   T    - registered tag, T[127:64] is tag word 0
module top (
   input  logic         CLK,
   input  logic         RST,
   input  logic [127:0] SK,
   input  logic [127:0] N,
   input  logic [63:0]  A,
   input  logic [63:0]  P,
   output logic [63:0]  C,
   output logic [127:0] T
);

   localparam logic [63:0] IV  = 64'h80400c0600000000;
   localparam logic [63:0] PAD = 64'h8000000000000000;

   typedef enum logic [2:0] {StLoad, StInit, StAd1, StAd2, StPt, StFin, StDone} state_e;

   state_e           st_q, st_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [4:0][63:0] s_q, s_d;
   logic [127:0]     k_q, k_d;
   logic [63:0]      a_q, a_d;
   logic [63:0]      p_q, p_d;
   logic [63:0]      cipher_q, cipher_d;
   logic [63:0]      c_q, c_d;
   logic [127:0]     t_q, t_d;

   logic             is_p12;
   logic             first;
   logic             last;
   logic [3:0]       rc_idx;
   logic [4:0][63:0] rnd_in;
   logic [4:0][63:0] rnd_out;

   function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned r);
      return (x >> r) | (x << (64 - r));
   endfunction

   // One Ascon round: constant addition, bit-sliced S-box, linear diffusion.
   function automatic logic [4:0][63:0] round_fn(input logic [4:0][63:0] x,
                                                 input logic [7:0]       rc);
      logic [63:0]      x0, x1, x2, x3, x4;
      logic [63:0]      t0, t1, t2, t3, t4;
      logic [4:0][63:0] r;
      x0 = x[0];
      x1 = x[1];
      x2 = x[2] ^ {56'd0, rc};
      x3 = x[3];
      x4 = x[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return r;
   endfunction

   // Round control: p6 phases reuse the last six p12 constants.
   always_comb begin
      is_p12 = (st_q == StInit) || (st_q == StFin);
      rc_idx = is_p12 ? cnt_q : cnt_q + 4'd6;
      first  = (cnt_q == 4'd0);
      last   = (cnt_q == (is_p12 ? 4'd11 : 4'd5));
   end

   // Phase-entry injections fold into the first round of each phase.
   always_comb begin
      rnd_in = s_q;
      if (first) begin
         unique case (st_q)
            StAd1: rnd_in[0] = s_q[0] ^ a_q;
            StAd2: rnd_in[0] = s_q[0] ^ PAD;
            StPt:  rnd_in[0] = s_q[0] ^ p_q;
            StFin: begin
               rnd_in[0] = s_q[0] ^ PAD;
               rnd_in[1] = s_q[1] ^ k_q[127:64];
               rnd_in[2] = s_q[2] ^ k_q[63:0];
            end
            default: ;
         endcase
      end
   end

   assign rnd_out = round_fn(rnd_in, {~rc_idx, rc_idx});

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      k_d      = k_q;
      a_d      = a_q;
      p_d      = p_q;
      cipher_d = cipher_q;
      c_d      = c_q;
      t_d      = t_q;
      unique case (st_q)
         StLoad: begin
            k_d    = SK;
            a_d    = A;
            p_d    = P;
            s_d[0] = IV;
            s_d[1] = SK[127:64];
            s_d[2] = SK[63:0];
            s_d[3] = N[127:64];
            s_d[4] = N[63:0];
            cnt_d  = 4'd0;
            st_d   = StInit;
         end
         StDone: begin
            c_d   = cipher_q;
            t_d   = {s_q[3] ^ k_q[127:64], s_q[4] ^ k_q[63:0]};
            cnt_d = 4'd0;
            st_d  = StLoad;
         end
         default: begin
            s_d   = rnd_out;
            cnt_d = cnt_q + 4'd1;
            // Ciphertext is the rate word right after plaintext injection.
            if (st_q == StPt && first) cipher_d = s_q[0] ^ p_q;
            if (last) begin
               cnt_d = 4'd0;
               unique case (st_q)
                  StInit: begin
                     s_d[3] = rnd_out[3] ^ k_q[127:64];
                     s_d[4] = rnd_out[4] ^ k_q[63:0];
                     st_d   = StAd1;
                  end
                  StAd1: st_d = StAd2;
                  StAd2: begin
                     s_d[4] = rnd_out[4] ^ 64'd1;
                     st_d   = StPt;
                  end
                  StPt:  st_d = StFin;
                  StFin: st_d = StDone;
                  default: st_d = StLoad;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q     <= StLoad;
         cnt_q    <= 4'd0;
         s_q      <= '0;
         k_q      <= '0;
         a_q      <= '0;
         p_q      <= '0;
         cipher_q <= '0;
         c_q      <= '0;
         t_q      <= '0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         k_q      <= k_d;
         a_q      <= a_d;
         p_q      <= p_d;
         cipher_q <= cipher_d;
         c_q      <= c_d;
         t_q      <= t_d;
      end
   end

   assign C = c_q;
   assign T = t_q;

endmodule

// File: tb/tb_top.sv
// Bench for the Ascon-128 core: drives whole operations and compares C/T
// against a software Ascon-128 model using a table S-box.
module tb_top;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [127:0] SK  = '0;
   logic [127:0] N   = '0;
   logic [63:0]  A   = '0;
   logic [63:0]  P   = '0;
   logic [63:0]  C;
   logic [127:0] T;

   int n_run  = 0;
   int n_fail = 0;

   localparam logic [63:0] IV  = 64'h80400c0600000000;
   localparam logic [63:0] PAD = 64'h8000000000000000;
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   always #5 CLK = ~CLK;

   top dut (
      .CLK(CLK),
      .RST(RST),
      .SK (SK),
      .N  (N),
      .A  (A),
      .P  (P),
      .C  (C),
      .T  (T)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] mror(input logic [63:0] x, input int r);
      return (x >> r) | (x << (64 - r));
   endfunction

   function automatic logic [0:4][63:0] perm(input logic [0:4][63:0] x, input int nr);
      logic [0:4][63:0] y;
      logic [4:0]       idx;
      logic [4:0]       v;
      for (int r = 12 - nr; r < 12; r++) begin
         x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            v   = SBOX[idx];
            y[0][b] = v[4];
            y[1][b] = v[3];
            y[2][b] = v[2];
            y[3][b] = v[1];
            y[4][b] = v[0];
         end
         x[0] = y[0] ^ mror(y[0], 19) ^ mror(y[0], 28);
         x[1] = y[1] ^ mror(y[1], 61) ^ mror(y[1], 39);
         x[2] = y[2] ^ mror(y[2], 1)  ^ mror(y[2], 6);
         x[3] = y[3] ^ mror(y[3], 10) ^ mror(y[3], 17);
         x[4] = y[4] ^ mror(y[4], 7)  ^ mror(y[4], 41);
      end
      return x;
   endfunction

   task automatic ascon_model(input logic [127:0] k, input logic [127:0] n,
                              input logic [63:0] a, input logic [63:0] p,
                              output logic [63:0] c, output logic [127:0] t);
      logic [0:4][63:0] x;
      x = {IV, k[127:64], k[63:0], n[127:64], n[63:0]};
      x = perm(x, 12);
      x[3] ^= k[127:64];
      x[4] ^= k[63:0];
      x[0] ^= a;
      x = perm(x, 6);
      x[0] ^= PAD;
      x = perm(x, 6);
      x[4] ^= 64'd1;
      x[0] ^= p;
      c = x[0];
      x = perm(x, 6);
      x[0] ^= PAD;
      x[1] ^= k[127:64];
      x[2] ^= k[63:0];
      x = perm(x, 12);
      t = {x[3] ^ k[127:64], x[4] ^ k[63:0]};
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   // Called when the next rising edge is a LOAD. Runs one 44-edge operation,
   // flags any output movement in edges 1..43, optionally swaps inputs mid-run.
   task automatic run_op(input logic [127:0] k, input logic [127:0] n,
                         input logic [63:0] a, input logic [63:0] p,
                         input bit mid, input logic [127:0] k2, input logic [127:0] n2,
                         input logic [63:0] a2, input logic [63:0] p2,
                         output bit changed, output logic [63:0] c_res,
                         output logic [127:0] t_res);
      logic [63:0]  c0;
      logic [127:0] t0;
      SK = k;
      N  = n;
      A  = a;
      P  = p;
      c0 = C;
      t0 = T;
      changed = 1'b0;
      for (int e = 1; e <= 43; e++) begin
         @(posedge CLK);
         #1;
         if (C !== c0 || T !== t0) changed = 1'b1;
         if (mid && e == 20) begin
            SK = k2;
            N  = n2;
            A  = a2;
            P  = p2;
         end
      end
      @(posedge CLK);
      #1;
      c_res = C;
      t_res = T;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_run++;
      if (C !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_c: got %h want 0", C);
      end
      n_run++;
      if (T !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_t: got %h want 0", T);
      end
   endtask

   task automatic test_zero();
      logic [63:0] ec, gc;
      logic [127:0] et, gt;
      bit ch;
      SK = '0; N = '0; A = '0; P = '0;
      do_reset();
      ascon_model('0, '0, '0, '0, ec, et);
      run_op('0, '0, '0, '0, 1'b0, '0, '0, '0, '0, ch, gc, gt);
      n_run++;
      if (ch !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_early_change: got %0b want 0", ch);
      end
      n_run++;
      if (gc !== ec) begin
         n_fail++;
         $display("FAIL zero_c: got %h want %h", gc, ec);
      end
      n_run++;
      if (gt !== et) begin
         n_fail++;
         $display("FAIL zero_t: got %h want %h", gt, et);
      end
   endtask

   task automatic test_vector();
      logic [127:0] kv;
      logic [63:0]  av;
      logic [63:0]  ec, gc;
      logic [127:0] et, gt;
      bit ch;
      kv = 128'h000102030405060708090A0B0C0D0E0F;
      av = 64'h0001020304050607;
      SK = kv; N = kv; A = av; P = av;
      do_reset();
      ascon_model(kv, kv, av, av, ec, et);
      for (int i = 0; i < 3; i++) begin
         run_op(kv, kv, av, av, 1'b0, '0, '0, '0, '0, ch, gc, gt);
         n_run++;
         if (gc !== ec || gt !== et) begin
            n_fail++;
            $display("FAIL vector_run%0d: got c=%h t=%h want c=%h t=%h", i, gc, gt, ec, et);
         end
         n_run++;
         if (ch !== 1'b0) begin
            n_fail++;
            $display("FAIL vector_hold%0d: got change=%0b want 0", i, ch);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] k, n;
      logic [63:0]  a, p, ec, gc;
      logic [127:0] et, gt;
      bit ch;
      for (int i = 0; i < 4; i++) begin
         k = rnd128();
         n = rnd128();
         a = {$urandom, $urandom};
         p = {$urandom, $urandom};
         ascon_model(k, n, a, p, ec, et);
         run_op(k, n, a, p, 1'b0, '0, '0, '0, '0, ch, gc, gt);
         n_run++;
         if (gc !== ec || gt !== et) begin
            n_fail++;
            $display("FAIL random%0d: got c=%h t=%h want c=%h t=%h", i, gc, gt, ec, et);
         end
         n_run++;
         if (ch !== 1'b0) begin
            n_fail++;
            $display("FAIL random_hold%0d: got change=%0b want 0", i, ch);
         end
      end
   endtask

   task automatic test_async_reset();
      int unsigned w;
      w = $urandom_range(1, 40);
      SK = rnd128();
      N  = rnd128();
      A  = {$urandom, $urandom};
      P  = {$urandom, $urandom};
      repeat (w) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      n_run++;
      if (C !== 64'd0 || T !== 128'd0) begin
         n_fail++;
         $display("FAIL async_reset: got c=%h t=%h want 0", C, T);
      end
   endtask

   task automatic test_midchange();
      logic [127:0] k1, n1, k2, n2;
      logic [63:0]  a1, p1, a2, p2, ec, gc;
      logic [127:0] et, gt;
      bit ch;
      k1 = rnd128(); n1 = rnd128(); a1 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
      k2 = rnd128(); n2 = rnd128(); a2 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
      SK = k1; N = n1; A = a1; P = p1;
      do_reset();
      ascon_model(k1, n1, a1, p1, ec, et);
      run_op(k1, n1, a1, p1, 1'b1, k2, n2, a2, p2, ch, gc, gt);
      n_run++;
      if (gc !== ec || gt !== et) begin
         n_fail++;
         $display("FAIL midchange_old: got c=%h t=%h want c=%h t=%h", gc, gt, ec, et);
      end
      ascon_model(k2, n2, a2, p2, ec, et);
      run_op(k2, n2, a2, p2, 1'b0, '0, '0, '0, '0, ch, gc, gt);
      n_run++;
      if (gc !== ec || gt !== et) begin
         n_fail++;
         $display("FAIL midchange_new: got c=%h t=%h want c=%h t=%h", gc, gt, ec, et);
      end
   endtask

   task automatic test_reset_fin();
      logic [127:0] k, n;
      logic [63:0]  a, p, ec, gc;
      logic [127:0] et, gt;
      bit ch;
      k = rnd128(); n = rnd128(); a = {$urandom, $urandom}; p = {$urandom, $urandom};
      SK = k; N = n; A = a; P = p;
      // Edge 1 is LOAD; edges 32..43 are FIN.
      repeat (35) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      n_run++;
      if (C !== 64'd0 || T !== 128'd0) begin
         n_fail++;
         $display("FAIL fin_reset_now: got c=%h t=%h want 0", C, T);
      end
      repeat (12) @(negedge CLK);
      n_run++;
      if (C !== 64'd0 || T !== 128'd0) begin
         n_fail++;
         $display("FAIL fin_reset_hold: got c=%h t=%h want 0", C, T);
      end
      RST = 1'b0;
      ascon_model(k, n, a, p, ec, et);
      run_op(k, n, a, p, 1'b0, '0, '0, '0, '0, ch, gc, gt);
      n_run++;
      if (gc !== ec || gt !== et) begin
         n_fail++;
         $display("FAIL fin_reset_rerun: got c=%h t=%h want c=%h t=%h", gc, gt, ec, et);
      end
      n_run++;
      if (ch !== 1'b0) begin
         n_fail++;
         $display("FAIL fin_reset_early: got change=%0b want 0", ch);
      end
   endtask

   task automatic test_bitflip();
      logic [127:0] k, n;
      logic [63:0]  a, p, pf, ec0, ec1, gc, mask;
      logic [127:0] et0, et1, gt;
      bit ch;
      int unsigned b;
      for (int i = 0; i < 2; i++) begin
         k = rnd128(); n = rnd128(); a = {$urandom, $urandom}; p = {$urandom, $urandom};
         b = $urandom_range(0, 63);
         mask = 64'd1 << b;
         pf = p ^ mask;
         ascon_model(k, n, a, p, ec0, et0);
         ascon_model(k, n, a, pf, ec1, et1);
         run_op(k, n, a, p, 1'b0, '0, '0, '0, '0, ch, gc, gt);
         n_run++;
         if (gc !== ec0 || gt !== et0) begin
            n_fail++;
            $display("FAIL bitflip_base%0d: got c=%h t=%h want c=%h t=%h", i, gc, gt, ec0, et0);
         end
         run_op(k, n, a, pf, 1'b0, '0, '0, '0, '0, ch, gc, gt);
         n_run++;
         if ((gc ^ ec0) !== mask) begin
            n_fail++;
            $display("FAIL bitflip_c%0d: got diff=%h want %h", i, gc ^ ec0, mask);
         end
         n_run++;
         if (gt === et0 || gt !== et1) begin
            n_fail++;
            $display("FAIL bitflip_t%0d: got t=%h want %h", i, gt, et1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_vector();
      test_random();
      test_async_reset();
      test_midchange();
      test_reset_fin();
      test_bitflip();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 SK  input  128  secret key K; K[127:64] is key word 0.
REQ-004 N  input  128  nonce; N[127:64] is nonce word 0.
REQ-005 A  input  64  one full associated-data block.
REQ-006 P  input  64  one full plaintext block.
REQ-007 C  output  64  ciphertext block, registered.
REQ-008 T  output  128  authentication tag, registered; T[127:64] is tag word 0.
REQ-009 The block SHALL have no parameters and no start/done pins; operation is free-running.

Function
REQ-010 The block SHALL implement Ascon-128 encryption: rate 64, a=12 rounds, b=6 rounds, IV = 0x80400c0600000000.
REQ-011 The state SHALL be five 64-bit words S0..S4, big-endian; S0 is the rate word.
REQ-012 Each permutation round SHALL execute in exactly one clock cycle (iterative core, one round instance).
REQ-013 The round SHALL apply three layers in order: constant addition, S-box, linear diffusion.
REQ-014 Constant addition: S2 ^= constant ((0xF-i)<<4)|i. For p12, i = 0..11. For p6, i = 6..11.
REQ-015 S-box: the standard Ascon 5-bit S-box, applied bit-sliced across S0..S4.
REQ-016 Linear layer, with ROR = rotate right:
- S0 ^= ROR19 ^ ROR28
- S1 ^= ROR61 ^ ROR39
- S2 ^= ROR1 ^ ROR6
- S3 ^= ROR10 ^ ROR17
- S4 ^= ROR7 ^ ROR41
REQ-017 FSM states: LOAD, INIT, AD1, AD2, PT, FIN, DONE. DONE returns to LOAD, so operations repeat back-to-back.
REQ-018 LOAD (1 cycle): capture SK, A, P into internal registers; S <= IV || K || N.
REQ-019 INIT (12 cycles): p12. On exit, S3 ^= K[127:64] and S4 ^= K[63:0].
REQ-020 AD1: S0 ^= A, then p6 (6 cycles).
REQ-021 AD2: S0 ^= 0x8000000000000000 (padding block), then p6 (6 cycles). On exit, S4 ^= 1 (domain separation).
REQ-022 PT: S0 ^= P; cipher register <= new S0; then p6 (6 cycles).
REQ-023 FIN: S0 ^= 0x8000000000000000; S1 ^= K[127:64]; S2 ^= K[63:0]; then p12 (12 cycles).
REQ-024 DONE (1 cycle):
- C <= cipher register.
- T <= {S3 ^ K[127:64], S4 ^ K[63:0]}.
REQ-025 Each XOR injection SHALL be combined into the first round of its phase; it SHALL NOT cost an extra cycle.
REQ-026 Operation length SHALL be exactly 44 cycles: 1 + 12 + 6 + 6 + 6 + 12 + 1.
REQ-027 C and T SHALL change only in DONE. They SHALL hold their value for the other 43 cycles.
REQ-028 Input changes after LOAD SHALL NOT affect the running operation. They SHALL take effect at the next LOAD.
REQ-029 A 4-bit round counter SHALL count 0..11 for p12 and 0..5 for p6, offset +6 for the constants. It SHALL wrap to 0 at each phase change.

Reset
REQ-030 While RST=1, regardless of CLK:
- C = 0, T = 0.
- State words, key/data registers and counter = 0.
- FSM = LOAD.
REQ-031 Asserting RST mid-operation SHALL abort the operation immediately; no partial C or T SHALL be published.
REQ-032 On the first rising CLK after RST falls, the block SHALL execute LOAD.

Verification
REQ-033 Assert RST at any cycle, inputs arbitrary -> C=0 and T=0 immediately, with no clock edge needed.
REQ-034 Release reset with SK=0, N=0, A=0, P=0 -> C and T first change exactly 44 cycles after the first post-reset edge, and are bit-exact with the Ascon-128 software model using one 64-bit AD block and one 64-bit PT block.
REQ-035 SK=N=0x000102030405060708090A0B0C0D0E0F, A=0x0001020304050607, P=0x0001020304050607 -> C and T match the software model; identical values are republished every 44 cycles.
REQ-036 Toggle A, P, SK or N in the middle of an operation -> the current result reflects the old inputs; the next DONE reflects the new inputs.
REQ-037 Assert RST during FIN -> outputs go to 0; after release, the first result equals the clean-run result for the same inputs.
REQ-038 Flip one bit of P only -> C differs in exactly that bit, and T changes.
